bus_arbiter: RTL and testbench

Round-robin arbiter for the shared 16-bit processor bus. It sits between the three bus requesters and the bus interface unit: the fetch control unit, the execution unit and the decoder. It grants one requester at a time and drives the BIU's `cs_biu` / `sel_biu` / address inputs from the winner's latched request. It holds the grant until `ready_bus` returns, then signals completion, or signals an error on timeout.

---
 rtl/bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared processor bus. Three requesters (fetch,
// execute, decode) compete for the bus interface unit; the winner's operation
// code and address are latched and driven to the BIU until ready_bus returns,
// or until the transfer times out.
//
// Handshake: a requester raises req[i] with its req_sel/req_addr valid and
// holds it until it sees done[i] or err[i], dropping it no later than the
// following cycle. The grant is then held until ready_bus (the BIU's "ready")
// is sampled high in BUS. If that never happens, the grant is held for
// TIMEOUT cycles. Every grant ends with exactly one done or err pulse.
module bus_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int AW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    req,
  input  logic [1:0]    req_sel0,
  input  logic [1:0]    req_sel1,
  input  logic [1:0]    req_sel2,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [AW-1:0] req_addr2,
  input  logic          ready_bus,
  output logic          cs_biu,
  output logic [1:0]    sel_biu,
  output logic [AW-1:0] biu_addr,
  output logic [2:0]    gnt,
  output logic [2:0]    done,
  output logic [2:0]    err,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on the last BUS cycle before a timeout abort.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [1:0]    ptr, ptr_n;
  logic [7:0]    cnt, cnt_n;
  logic          cs_n, busy_n;
  logic [1:0]    sel_n;
  logic [AW-1:0] addr_n;
  logic [2:0]    gnt_n, done_n, err_n;
  logic [1:0]    win;
  logic          win_ok;
  logic [3:0]    req_ext;

  // Pad the request vector so a 2-bit index can never fall outside it.
  assign req_ext   = {1'b0, req};
  assign state_dbg = state;

  // Round-robin search: start just after the last winner, wrap modulo 3.
  always_comb begin
    logic [1:0] cand;
    win    = 2'd0;
    win_ok = 1'b0;
    cand   = ptr;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!win_ok && req_ext[cand]) begin
        win    = cand;
        win_ok = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    cs_n    = cs_biu;
    sel_n   = sel_biu;
    addr_n  = biu_addr;
    gnt_n   = gnt;
    busy_n  = busy;
    done_n  = 3'b000;
    err_n   = 3'b000;
    case (state)
      IDLE: begin
        if (win_ok) begin
          state_n = BUS;
          ptr_n   = win;
          cnt_n   = 8'd0;
          cs_n    = 1'b1;
          busy_n  = 1'b1;
          gnt_n   = 3'b001 << win;
          case (win)
            2'd0:    begin sel_n = req_sel0; addr_n = req_addr0; end
            2'd1:    begin sel_n = req_sel1; addr_n = req_addr1; end
            default: begin sel_n = req_sel2; addr_n = req_addr2; end
          endcase
        end
      end
      BUS: begin
        if (ready_bus) begin
          state_n = DONE;
          cs_n    = 1'b0;
          gnt_n   = 3'b000;
          done_n  = gnt;
        end else if (cnt == LAST_CNT) begin
          state_n = DONE;
          cs_n    = 1'b0;
          gnt_n   = 3'b000;
          err_n   = gnt;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        cs_n    = 1'b0;
        gnt_n   = 3'b000;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 2'd2;
      cnt      <= 8'd0;
      cs_biu   <= 1'b0;
      sel_biu  <= 2'b00;
      biu_addr <= '0;
      gnt      <= 3'b000;
      done     <= 3'b000;
      err      <= 3'b000;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      cs_biu   <= cs_n;
      sel_biu  <= sel_n;
      biu_addr <= addr_n;
      gnt      <= gnt_n;
      done     <= done_n;
      err      <= err_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level round-robin model.
module tb_bus_arbiter;

  localparam int TO = 15;
  localparam int AW = 16;

  logic          clk, reset, ready_bus;
  logic [2:0]    req;
  logic [1:0]    req_sel0, req_sel1, req_sel2;
  logic [AW-1:0] req_addr0, req_addr1, req_addr2;
  logic          cs_biu, busy;
  logic [1:0]    sel_biu, state_dbg;
  logic [AW-1:0] biu_addr;
  logic [2:0]    gnt, done, err;

  int total = 0;
  int bad   = 0;
  int last  = 2;                 // model: index of the last granted requester
  logic [1:0] exp_q[$];          // expected grant order

  bus_arbiter #(.TIMEOUT(TO), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_sel0(req_sel0), .req_sel1(req_sel1), .req_sel2(req_sel2),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
    .ready_bus(ready_bus), .cs_biu(cs_biu), .sel_biu(sel_biu),
    .biu_addr(biu_addr), .gnt(gnt), .done(done), .err(err), .busy(busy),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: first requester after prev (mod 3) that is asking.
  function automatic int rr_pick(int prev, logic [2:0] r);
    for (int k = 1; k <= 3; k++)
      if (r[(prev + k) % 3]) return (prev + k) % 3;
    return -1;
  endfunction

  task automatic drive_ops(input logic [1:0] s0, s1, s2,
                           input logic [AW-1:0] a0, a1, a2);
    req_sel0 = s0; req_sel1 = s1; req_sel2 = s2;
    req_addr0 = a0; req_addr1 = a1; req_addr2 = a2;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 3'b000; ready_bus = 1'b0;
    drive_ops(2'b00, 2'b00, 2'b00, '0, '0, '0);
    repeat (2) @(negedge clk);
    total++;
    if ({cs_biu, sel_biu, biu_addr, gnt, done, err, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got cs=%b sel=%b addr=%h gnt=%b done=%b err=%b busy=%b want all 0",
               cs_biu, sel_biu, biu_addr, gnt, done, err, busy);
    end
    reset = 1'b0;
    last  = 2;
    @(negedge clk);
    total++;
    if ({gnt, busy} !== 4'b0) begin
      bad++;
      $display("FAIL reset_idle: got gnt=%b busy=%b want 0", gnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 4; i++) begin
      w = rr_pick(last, 3'b111);
      last = w;
      exp_q.push_back(2'(w));
    end
    req = 3'b111; ready_bus = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      @(negedge clk);
      total++;
      if (gnt !== (3'b001 << e) || cs_biu !== 1'b1) begin
        bad++;
        $display("FAIL b2b_grant%0d: got gnt=%b cs=%b want gnt=%b cs=1", i, gnt, cs_biu, 3'b001 << e);
      end
      @(negedge clk);
      total++;
      if (done !== (3'b001 << e) || err !== 3'b000 || gnt !== 3'b000) begin
        bad++;
        $display("FAIL b2b_done%0d: got done=%b err=%b gnt=%b want done=%b", i, done, err, gnt, 3'b001 << e);
      end
      @(negedge clk);
      total++;
      if (done !== 3'b000 || busy !== 1'b0 || gnt !== 3'b000) begin
        bad++;
        $display("FAIL b2b_idle%0d: got done=%b busy=%b gnt=%b want 0", i, done, busy, gnt);
      end
      if (i == 3) begin req = 3'b000; ready_bus = 1'b0; end
    end
  endtask

  task automatic test_single();
    req = 3'b001;
    drive_ops(2'b01, 2'b10, 2'b11, 16'h0040, 16'h1111, 16'h2222);
    last = rr_pick(last, 3'b001);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if ({gnt, cs_biu, sel_biu, biu_addr, done} !== {3'b001, 1'b1, 2'b01, 16'h0040, 3'b000}) begin
        bad++;
        $display("FAIL single_bus%0d: got gnt=%b cs=%b sel=%b addr=%h done=%b want 001/1/01/0040/000",
                 c, gnt, cs_biu, sel_biu, biu_addr, done);
      end
      if (c == 3) ready_bus = 1'b1;
    end
    @(negedge clk);
    ready_bus = 1'b0; req = 3'b000;
    total++;
    if ({done, err, cs_biu, gnt} !== {3'b001, 3'b000, 1'b0, 3'b000}) begin
      bad++;
      $display("FAIL single_done: got done=%b err=%b cs=%b gnt=%b want 001/000/0/000", done, err, cs_biu, gnt);
    end
    @(negedge clk);
    total++;
    if (done !== 3'b000) begin
      bad++;
      $display("FAIL single_pulse: got done=%b want 000", done);
    end
  endtask

  task automatic test_timeout();
    int hi = 0;
    req = 3'b010; ready_bus = 1'b0;
    last = rr_pick(last, 3'b010);
    for (int c = 0; c < TO + 10; c++) begin
      @(negedge clk);
      if (!cs_biu) break;
      hi++;
    end
    total++;
    if (hi !== TO) begin
      bad++;
      $display("FAIL timeout_len: got cs high %0d cycles want %0d", hi, TO);
    end
    total++;
    if (err !== 3'b010 || done !== 3'b000) begin
      bad++;
      $display("FAIL timeout_err: got err=%b done=%b want err=010 done=000", err, done);
    end
    req = 3'b000;
    @(negedge clk);
    total++;
    if (err !== 3'b000) begin
      bad++;
      $display("FAIL timeout_pulse: got err=%b want 000", err);
    end
  endtask

  task automatic test_ready_at_timeout();
    int hi = 0;
    req = 3'b001;
    last = rr_pick(last, 3'b001);
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      if (cs_biu) hi++;
      if (c == TO) ready_bus = 1'b1;
    end
    @(negedge clk);
    ready_bus = 1'b0; req = 3'b000;
    total++;
    if (hi !== TO || done !== 3'b001 || err !== 3'b000) begin
      bad++;
      $display("FAIL ready_at_timeout: got hi=%0d done=%b err=%b want %0d/001/000", hi, done, err, TO);
    end
    @(negedge clk);
  endtask

  task automatic test_latch();
    req = 3'b100;
    drive_ops(2'b00, 2'b00, 2'b11, 16'h0000, 16'h0000, 16'hBEEF);
    last = rr_pick(last, 3'b100);
    @(negedge clk);
    total++;
    if (gnt !== 3'b100) begin
      bad++;
      $display("FAIL latch_grant: got gnt=%b want 100", gnt);
    end
    req = 3'b000;
    drive_ops(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h1234);
    @(negedge clk);
    total++;
    if (sel_biu !== 2'b11 || biu_addr !== 16'hBEEF || gnt !== 3'b100) begin
      bad++;
      $display("FAIL latch_hold: got sel=%b addr=%h gnt=%b want 11/beef/100", sel_biu, biu_addr, gnt);
    end
    ready_bus = 1'b1;
    @(negedge clk);
    ready_bus = 1'b0;
    total++;
    if (done !== 3'b100 || sel_biu !== 2'b11 || biu_addr !== 16'hBEEF) begin
      bad++;
      $display("FAIL latch_done: got done=%b sel=%b addr=%h want 100/11/beef", done, sel_biu, biu_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    req = 3'b001;
    drive_ops(2'b10, 2'b01, 2'b01, 16'hAAAA, 16'h5555, 16'h3333);
    @(negedge clk);
    total++;
    if (cs_biu !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre: got cs=%b want 1", cs_biu);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({cs_biu, sel_biu, biu_addr, gnt, done, err, busy} !== '0) begin
      bad++;
      $display("FAIL areset_now: got cs=%b sel=%b addr=%h gnt=%b done=%b err=%b busy=%b want all 0",
               cs_biu, sel_biu, biu_addr, gnt, done, err, busy);
    end
    @(negedge clk);
    reset = 1'b0; req = 3'b110;
    last = 2;
    last = rr_pick(last, 3'b110);
    @(negedge clk);
    total++;
    if (gnt !== (3'b001 << last) || done !== 3'b000) begin
      bad++;
      $display("FAIL areset_first: got gnt=%b done=%b want gnt=%b done=000", gnt, done, 3'b001 << last);
    end
    ready_bus = 1'b1;
    @(negedge clk);
    ready_bus = 1'b0; req = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0]    pend, eg;
    logic [1:0]    s[3];
    logic [AW-1:0] a[3];
    int            w, wt, ncyc;
    logic          ok;
    pend = 3'($urandom_range(1, 7));
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3; i++) begin s[i] = 2'($urandom); a[i] = AW'($urandom); end
      drive_ops(s[0], s[1], s[2], a[0], a[1], a[2]);
      req = pend;
      wt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 3) : $urandom_range(0, 3);
      w = rr_pick(last, pend);
      last = w;
      eg = 3'b001 << w;
      ok = (wt + 1 <= TO);
      ncyc = ok ? wt + 1 : TO;
      for (int c = 1; c <= ncyc; c++) begin
        @(negedge clk);
        total++;
        if ({gnt, cs_biu, busy, done, err, sel_biu, biu_addr} !== {eg, 1'b1, 1'b1, 3'b000, 3'b000, s[w], a[w]}) begin
          bad++;
          $display("FAIL rand_bus n=%0d c=%0d: got gnt=%b cs=%b busy=%b done=%b err=%b sel=%b addr=%h want gnt=%b sel=%b addr=%h",
                   n, c, gnt, cs_biu, busy, done, err, sel_biu, biu_addr, eg, s[w], a[w]);
        end
        drive_ops(2'($urandom), 2'($urandom), 2'($urandom), AW'($urandom), AW'($urandom), AW'($urandom));
        if ($urandom_range(0, 3) == 0) pend[w] = 1'b0;
        req = pend;
        ready_bus = (c == wt + 1);
      end
      @(negedge clk);
      total++;
      if ({gnt, cs_biu, busy, done, err, sel_biu, biu_addr} !==
          {3'b000, 1'b0, 1'b1, ok ? eg : 3'b000, ok ? 3'b000 : eg, s[w], a[w]}) begin
        bad++;
        $display("FAIL rand_end n=%0d: got gnt=%b cs=%b busy=%b done=%b err=%b sel=%b addr=%h want done=%b err=%b",
                 n, gnt, cs_biu, busy, done, err, sel_biu, biu_addr, ok ? eg : 3'b000, ok ? 3'b000 : eg);
      end
      pend[w] = 1'b0;
      pend = pend | 3'($urandom_range(0, 7));
      if (pend == 3'b000) pend = 3'($urandom_range(1, 7));
      req = pend;
      ready_bus = 1'($urandom);
      @(negedge clk);
      total++;
      if ({gnt, cs_biu, busy, done, err, sel_biu, biu_addr} !== {3'b000, 1'b0, 1'b0, 3'b000, 3'b000, s[w], a[w]}) begin
        bad++;
        $display("FAIL rand_idle n=%0d: got gnt=%b cs=%b busy=%b done=%b err=%b sel=%b addr=%h want idle, sel=%b addr=%h",
                 n, gnt, cs_biu, busy, done, err, sel_biu, biu_addr, s[w], a[w]);
      end
    end
    req = 3'b000; ready_bus = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_timeout();
    test_ready_at_timeout();
    test_latch();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
